// File: rtl/pulpemu_ctrl_pkg.sv
// Shared FSM encoding and PS control-word bit positions for the PULP emulation control bridge.
package pulpemu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RST_HOLD   = 3'd1,
      ST_FETCH_WAIT = 3'd2,
      ST_RUN        = 3'd3,
      ST_DONE       = 3'd4
   } state_t;

   localparam int RUN_BIT   = 31;
   localparam int FETCH_BIT = 0;
   localparam int CLR_BIT   = 1;
   localparam int MODE_BIT  = 2;

endpackage

// File: rtl/pulpemu_sync.sv
// Multi-flop synchronizer for quasi-static status bits crossing into ps7_clk.
// Latency is STAGES cycles; chain clears to zero on reset.
module pulpemu_sync #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             ps7_clk,
   input  logic             ps7_rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
      if (!ps7_rst_n) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/pulpemu_ctrl_bridge.sv
// PS-to-SoC control bridge: sequences SoC reset/fetch enable from the PS run bit and
// reports synchronized SoC status (level or sticky) plus an end-of-computation pulse.
module pulpemu_ctrl_bridge #(
   parameter int NUM_CH      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int RST_HOLD    = 16,
   parameter int FETCH_DLY   = 8,
   parameter int EOC_BIT     = 0
) (
   input  logic              ps7_clk,
   input  logic              ps7_rst_n,
   input  logic [31:0]       ctrl_i,
   input  logic [NUM_CH-1:0] status_i,
   output logic              soc_rst_no,
   output logic              fetch_en_o,
   output logic [NUM_CH-1:0] status_o,
   output logic [2:0]        state_o,
   output logic              eoc_irq_o
);

   import pulpemu_ctrl_pkg::*;

   localparam logic [7:0] RST_LOAD   = 8'(RST_HOLD - 1);
   localparam logic [7:0] FETCH_LOAD = 8'(FETCH_DLY);

   logic [31:0]       ctrl_q;
   logic [NUM_CH-1:0] status_s;
   state_t            state, state_nxt;
   logic [7:0]        cnt, cnt_nxt;
   logic              eoc_prev, clr_prev, eoc_rise;
   logic              soc_rst_nxt, fetch_en_nxt, eoc_irq_nxt;
   logic              ctrl_unused;

   assign ctrl_unused = ^ctrl_q[30:3];

   pulpemu_sync #(.WIDTH(NUM_CH), .STAGES(SYNC_STAGES)) u_sync (
      .ps7_clk   (ps7_clk),
      .ps7_rst_n (ps7_rst_n),
      .d         (status_i),
      .q         (status_s)
   );

   // eoc_prev is held high outside RUN so a level already present on entry is not an edge
   assign eoc_rise = status_s[EOC_BIT] & ~eoc_prev;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      eoc_irq_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ctrl_q[RUN_BIT]) begin
               state_nxt = ST_RST_HOLD;
               cnt_nxt   = RST_LOAD;
            end
         end
         ST_RST_HOLD: begin
            if (cnt == 8'd0) begin
               state_nxt = ST_FETCH_WAIT;
               cnt_nxt   = FETCH_LOAD;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         ST_FETCH_WAIT: begin
            if (cnt == 8'd0) state_nxt = ST_RUN;
            else             cnt_nxt   = cnt - 8'd1;
         end
         ST_RUN: begin
            if (eoc_rise) begin
               state_nxt   = ST_DONE;
               eoc_irq_nxt = 1'b1;
            end
         end
         ST_DONE:  state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (!ctrl_q[RUN_BIT]) begin
         state_nxt   = ST_IDLE;
         eoc_irq_nxt = 1'b0;
      end
      soc_rst_nxt  = (state_nxt != ST_IDLE) && (state_nxt != ST_RST_HOLD);
      fetch_en_nxt = (state_nxt == ST_RUN) && ctrl_q[FETCH_BIT];
   end

   always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
      if (!ps7_rst_n) begin
         ctrl_q     <= '0;
         state      <= ST_IDLE;
         cnt        <= '0;
         eoc_prev   <= 1'b1;
         soc_rst_no <= 1'b0;
         fetch_en_o <= 1'b0;
         eoc_irq_o  <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_i;
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         eoc_prev   <= (state == ST_RUN) ? status_s[EOC_BIT] : 1'b1;
         soc_rst_no <= soc_rst_nxt;
         fetch_en_o <= fetch_en_nxt;
         eoc_irq_o  <= eoc_irq_nxt;
      end
   end

   // A clear edge overrides sticky accumulation, but bits set this cycle still show
   always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
      if (!ps7_rst_n) begin
         clr_prev <= 1'b0;
         status_o <= '0;
      end else begin
         clr_prev <= ctrl_q[CLR_BIT];
         if (ctrl_q[CLR_BIT] && !clr_prev) status_o <= status_s;
         else if (ctrl_q[MODE_BIT])        status_o <= status_o | status_s;
         else                              status_o <= status_s;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_pulpemu_ctrl_bridge.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_pulpemu_ctrl_bridge;

   typedef struct {
      string       name;
      int          sel;
      int          cyc;
      logic [31:0] val;
   } exp_t;

   localparam int S_SOC = 0, S_FETCH = 1, S_STAT = 2, S_STATE = 3, S_EOC = 4, S_SOC1 = 5, S_FETCH1 = 6;

   logic        ps7_clk = 1'b0;
   logic        ps7_rst_n = 1'b0;
   logic [31:0] ctrl_i = '0;
   logic [31:0] status_i = '0;
   logic [31:0] ctrl1 = '0;
   logic [7:0]  status1 = '0;

   logic        soc_rst_no, fetch_en_o, eoc_irq_o;
   logic [31:0] status_o;
   logic [2:0]  state_o;
   logic        soc_rst_no1, fetch_en_o1, eoc_irq_o1;
   logic [7:0]  status_o1;
   logic [2:0]  state_o1;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   pulpemu_ctrl_bridge dut (
      .ps7_clk    (ps7_clk),
      .ps7_rst_n  (ps7_rst_n),
      .ctrl_i     (ctrl_i),
      .status_i   (status_i),
      .soc_rst_no (soc_rst_no),
      .fetch_en_o (fetch_en_o),
      .status_o   (status_o),
      .state_o    (state_o),
      .eoc_irq_o  (eoc_irq_o)
   );

   pulpemu_ctrl_bridge #(.NUM_CH(8), .RST_HOLD(1), .FETCH_DLY(0)) dut_fast (
      .ps7_clk    (ps7_clk),
      .ps7_rst_n  (ps7_rst_n),
      .ctrl_i     (ctrl1),
      .status_i   (status1),
      .soc_rst_no (soc_rst_no1),
      .fetch_en_o (fetch_en_o1),
      .status_o   (status_o1),
      .state_o    (state_o1),
      .eoc_irq_o  (eoc_irq_o1)
   );

   always #5 ps7_clk = ~ps7_clk;
   always @(posedge ps7_clk) cyc <= cyc + 1;

   function automatic logic [31:0] sample(input int sel);
      case (sel)
         S_SOC:    return {31'd0, soc_rst_no};
         S_FETCH:  return {31'd0, fetch_en_o};
         S_STAT:   return status_o;
         S_STATE:  return {29'd0, state_o};
         S_EOC:    return {31'd0, eoc_irq_o};
         S_SOC1:   return {31'd0, soc_rst_no1};
         S_FETCH1: return {31'd0, fetch_en_o1};
         default:  return 32'hdead_beef;
      endcase
   endfunction

   task automatic expect_at(input string name, input int sel, input int off, input logic [31:0] val);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.cyc  = cyc + off;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge ps7_clk);
      #1;
   endtask

   always @(negedge ps7_clk) begin : monitor
      exp_t        keep[$];
      logic [31:0] got;
      keep = {};
      foreach (sb[i]) begin
         if (sb[i].cyc == cyc) begin
            got = sample(sb[i].sel);
            n_chk++;
            if (got === sb[i].val) n_pass++;
            else $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", sb[i].name, cyc, got, sb[i].val);
         end else if (sb[i].cyc < cyc) begin
            n_chk++;
            $display("FAIL %s: check for cyc %0d was missed (now %0d)", sb[i].name, sb[i].cyc, cyc);
         end else begin
            keep.push_back(sb[i]);
         end
      end
      sb = keep;
   end

   initial begin
      // reset state
      wait_cyc(1);
      expect_at("rst_soc",   S_SOC,   0, 0);
      expect_at("rst_fetch", S_FETCH, 0, 0);
      expect_at("rst_stat",  S_STAT,  0, 0);
      expect_at("rst_state", S_STATE, 0, 0);
      expect_at("rst_eoc",   S_EOC,   0, 0);
      wait_cyc(2);
      ps7_rst_n = 1'b1;
      wait_cyc(2);

      // run sequence, default and fast parameter sets
      ctrl_i = 32'h8000_0001;
      ctrl1  = 32'h8000_0001;
      expect_at("seq_state_hold", S_STATE, 2, 1);
      expect_at("seq_soc_pre",    S_SOC,   17, 0);
      expect_at("seq_soc_rise",   S_SOC,   18, 1);
      expect_at("seq_fetch_pre",  S_FETCH, 26, 0);
      expect_at("seq_fetch_rise", S_FETCH, 27, 1);
      expect_at("seq_state_run",  S_STATE, 27, 3);
      expect_at("fast_soc_pre",   S_SOC1,  2, 0);
      expect_at("fast_soc_rise",  S_SOC1,  3, 1);
      expect_at("fast_fetch_pre", S_FETCH1, 3, 0);
      expect_at("fast_fetch_rise",S_FETCH1, 4, 1);
      wait_cyc(30);

      // end of computation edge
      status_i = 32'h1;
      expect_at("eoc_pre",       S_EOC,   2, 0);
      expect_at("eoc_pulse",     S_EOC,   3, 1);
      expect_at("eoc_post",      S_EOC,   4, 0);
      expect_at("eoc_fetch_pre", S_FETCH, 2, 1);
      expect_at("eoc_fetch_off", S_FETCH, 3, 0);
      expect_at("eoc_state_run", S_STATE, 2, 3);
      expect_at("eoc_state_done",S_STATE, 3, 4);
      expect_at("level_stat_0",  S_STAT,  2, 0);
      expect_at("level_stat_1",  S_STAT,  3, 1);
      wait_cyc(6);

      // run bit dropped in DONE
      ctrl_i = 32'h0;
      expect_at("done_state_hold", S_STATE, 1, 4);
      expect_at("done_soc_hold",   S_SOC,   1, 1);
      expect_at("done_state_idle", S_STATE, 2, 0);
      expect_at("done_soc_low",    S_SOC,   2, 0);
      wait_cyc(4);

      // eoc already high on RUN entry must not complete
      ctrl_i = 32'h8000_0001;
      expect_at("hi_state_run",  S_STATE, 27, 3);
      expect_at("hi_eoc_quiet",  S_EOC,   28, 0);
      expect_at("hi_state_stay", S_STATE, 34, 3);
      expect_at("hi_stat",       S_STAT,  34, 1);
      wait_cyc(36);

      // asynchronous reset in RUN, then rerun
      ps7_rst_n = 1'b0;
      status_i  = 32'h0;
      expect_at("arst_soc",   S_SOC,   0, 0);
      expect_at("arst_fetch", S_FETCH, 0, 0);
      expect_at("arst_stat",  S_STAT,  0, 0);
      expect_at("arst_state", S_STATE, 0, 0);
      expect_at("arst_eoc",   S_EOC,   0, 0);
      wait_cyc(2);
      ps7_rst_n = 1'b1;
      expect_at("rerun_soc_pre",    S_SOC,   17, 0);
      expect_at("rerun_soc_rise",   S_SOC,   18, 1);
      expect_at("rerun_fetch_pre",  S_FETCH, 26, 0);
      expect_at("rerun_fetch_rise", S_FETCH, 27, 1);
      wait_cyc(30);

      // abort during reset hold at counter 5
      ctrl_i = 32'h0;
      wait_cyc(3);
      ctrl_i = 32'h8000_0001;
      wait_cyc(12);
      ctrl_i = 32'h0;
      expect_at("abort_state_hold", S_STATE, 1, 1);
      expect_at("abort_state_idle", S_STATE, 2, 0);
      expect_at("abort_soc_low",    S_SOC,   8, 0);
      expect_at("abort_fetch_low",  S_FETCH, 15, 0);
      wait_cyc(18);

      // sticky accumulation, clear edge, return to level mode
      ctrl_i = 32'h4;
      wait_cyc(3);
      status_i = 32'h1;
      wait_cyc(2);
      status_i = 32'h0;
      wait_cyc(2);
      status_i = 32'h4;
      wait_cyc(2);
      status_i = 32'h0;
      wait_cyc(6);
      expect_at("sticky_acc", S_STAT, 0, 32'h5);
      status_i = 32'h2;
      wait_cyc(4);
      expect_at("sticky_or", S_STAT, 0, 32'h7);
      ctrl_i = 32'h6;
      expect_at("clr_pre",   S_STAT, 1, 32'h7);
      expect_at("clr_edge",  S_STAT, 2, 32'h2);
      expect_at("clr_after", S_STAT, 4, 32'h2);
      wait_cyc(5);
      ctrl_i = 32'h2;
      expect_at("mode_keep0", S_STAT, 2, 32'h2);
      expect_at("mode_keep1", S_STAT, 3, 32'h2);
      wait_cyc(4);
      status_i = 32'h0;
      expect_at("level_hold", S_STAT, 1, 32'h2);
      expect_at("level_drop", S_STAT, 4, 32'h0);

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge ps7_clk);
      wait_cyc(1);
      foreach (sb[i]) begin
         n_chk++;
         $display("FAIL %s: check for cyc %0d never evaluated", sb[i].name, sb[i].cyc);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
